// File: rtl/icfo_pkg.sv
// Shared sizing helpers and reset constants for the approximate-magnitude arbiter.
package icfo_pkg;

    function automatic int mag_width(input int width);
        return width + 1;
    endfunction

    function automatic int id_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    // Pointer holds the index with highest priority; 0 after reset.
    localparam int RR_PTR_RST = 0;

endpackage

// File: rtl/icfo_mag_core.sv
// Two-stage |re|,|im| -> max + min/2 pipeline with sideband ID; result 2 cycles after input.
// Both stages freeze while the output is valid and not accepted; empty stages are overwritten.
module icfo_mag_core
    import icfo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDW   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_vld,
    input  logic [WIDTH-1:0]             i_re,
    input  logic [WIDTH-1:0]             i_im,
    input  logic [IDW-1:0]               i_id,
    input  logic                         i_rdy,
    output logic                         o_vld,
    output logic [mag_width(WIDTH)-1:0]  o_mag,
    output logic [IDW-1:0]               o_id,
    output logic                         o_busy,
    output logic                         o_stall
);

    localparam int MW = mag_width(WIDTH);

    function automatic logic [WIDTH-1:0] abs_u(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [IDW-1:0]   r_s1_id;
    logic             r_s2_vld;
    logic [MW-1:0]    r_mag;
    logic [IDW-1:0]   r_id;

    logic             w_stall;
    logic [WIDTH-1:0] w_abs_re;
    logic [WIDTH-1:0] w_abs_im;
    logic [MW-1:0]    w_a_ext;
    logic [MW-1:0]    w_b_ext;
    logic [MW-1:0]    w_mag;

    assign w_stall  = r_s2_vld & ~i_rdy;
    assign w_abs_re = abs_u(i_re);
    assign w_abs_im = abs_u(i_im);
    assign w_a_ext  = {1'b0, r_s1_a};
    assign w_b_ext  = {1'b0, r_s1_b};
    // A tie takes the second branch; both branches give the same value then.
    assign w_mag    = (r_s1_a > r_s1_b) ? (w_a_ext + (w_b_ext >> 1))
                                        : (w_b_ext + (w_a_ext >> 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_id  <= '0;
            r_s2_vld <= 1'b0;
            r_mag    <= '0;
            r_id     <= '0;
        end else if (!w_stall) begin
            r_s1_vld <= i_vld;
            if (i_vld) begin
                r_s1_a  <= w_abs_re;
                r_s1_b  <= w_abs_im;
                r_s1_id <= i_id;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_mag <= w_mag;
                r_id  <= r_s1_id;
            end
        end
    end

    assign o_vld   = r_s2_vld;
    assign o_mag   = r_mag;
    assign o_id    = r_id;
    assign o_busy  = r_s1_vld | r_s2_vld;
    assign o_stall = w_stall;

endmodule

// File: rtl/icfo_mag_arbiter.sv
// Round-robin share of one magnitude pipeline among NREQ streams; result 2 cycles after transfer.
// Output stall drops every req_rdy and freezes the pointer; results keep grant order and ID.
module icfo_mag_arbiter
    import icfo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2,
    parameter int IDW   = id_width(NREQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_en,
    input  logic [NREQ-1:0]              req_val,
    output logic [NREQ-1:0]              req_rdy,
    input  logic [NREQ*WIDTH-1:0]        req_real,
    input  logic [NREQ*WIDTH-1:0]        req_imag,
    output logic [mag_width(WIDTH)-1:0]  mag,
    output logic [IDW-1:0]               mag_id,
    output logic                         mag_val,
    input  logic                         mag_rdy,
    output logic                         busy
);

    logic [IDW-1:0]   r_ptr;
    logic [NREQ-1:0]  w_cand;
    logic [NREQ-1:0]  w_onehot;
    logic             w_found;
    logic [IDW-1:0]   w_gnt;
    int               w_idx;
    logic             w_stall;
    logic             w_xfer;
    logic [WIDTH-1:0] w_re;
    logic [WIDTH-1:0] w_im;

    assign w_cand = req_val & req_en;

    // Scan from the pointer upward with wrap; first candidate wins.
    always_comb begin
        w_found  = 1'b0;
        w_gnt    = '0;
        w_onehot = '0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && w_cand[w_idx]) begin
                w_found         = 1'b1;
                w_gnt           = IDW'(w_idx);
                w_onehot[w_idx] = 1'b1;
            end
        end
    end

    assign w_xfer  = rst & ~w_stall & w_found;
    assign req_rdy = w_xfer ? w_onehot : '0;
    assign w_re    = req_real[w_gnt*WIDTH +: WIDTH];
    assign w_im    = req_imag[w_gnt*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= IDW'(RR_PTR_RST);
        end else if (w_xfer) begin
            r_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : (w_gnt + IDW'(1));
        end
    end

    icfo_mag_core #(
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (w_xfer),
        .i_re    (w_re),
        .i_im    (w_im),
        .i_id    (w_gnt),
        .i_rdy   (mag_rdy),
        .o_vld   (mag_val),
        .o_mag   (mag),
        .o_id    (mag_id),
        .o_busy  (busy),
        .o_stall (w_stall)
    );

endmodule

// File: doc/icfo_mag_arbiter.md
Name: icfo_mag_arbiter

Overview:
- Shares one approximate-magnitude datapath (|re|,|im| → max + min/2) between NREQ sample streams in the OFDM RX sync path, e.g. autocorrelation and cross-correlation outputs feeding CFO/timing detectors.
- Round-robin arbiter with valid/ready on each requester and a 2-stage stallable pipeline.
- Each result carries the ID of the requester that produced it.

Parameters:
- WIDTH, 16, bit width of the signed two's-complement real/imag inputs.
- NREQ, 2, number of requesters (2..4).
- IDW, 1, width of the requester ID; must satisfy 2^IDW ≥ NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-low (asserted when 0).
- req_en  in  NREQ  per-requester enable mask; a disabled requester is never granted.
- req_val  in  NREQ  per-requester sample valid.
- req_rdy  out  NREQ  per-requester ready; a sample transfers when val & rdy are both 1.
- req_real  in  NREQ*WIDTH  packed real parts; requester i occupies bits [i*WIDTH +: WIDTH].
- req_imag  in  NREQ*WIDTH  packed imag parts, same packing.
- mag  out  WIDTH+1  unsigned approximate magnitude.
- mag_id  out  IDW  requester index for mag.
- mag_val  out  1  result valid.
- mag_rdy  in  1  downstream ready.
- busy  out  1  1 while either pipeline stage holds data.

Behaviour:
- Reset (rst=0 at a clock edge):
  - all pipeline valids cleared; mag_val=0, busy=0;
  - mag=0, mag_id=0;
  - round-robin pointer set so requester 0 has highest priority;
  - req_rdy is all-zero while rst=0.
- Stall: stall = mag_val & ~mag_rdy. While stalled, both stages hold their contents, req_rdy=0, and the pointer is frozen.
- Arbitration (combinational, single cycle):
  - candidates are req_val & req_en;
  - search order starts at (last_grant+1) mod NREQ and wraps;
  - at most one req_rdy bit is high: the first candidate found, and only when not stalled;
  - req_rdy may depend combinationally on req_val and mag_rdy;
  - last_grant updates only on an actual transfer; if no candidate, the pointer holds.
- Stage 1 (abs), registered on transfer:
  - |x| = x[WIDTH-1] ? (~x + 1) : x, held in WIDTH unsigned bits;
  - the most negative value -2^(WIDTH-1) maps to 2^(WIDTH-1), with no saturation;
  - the granted ID is stored alongside.
- Stage 2 (mag), registered:
  - mag = (a > b) ? a + (b>>1) : b + (a>>1), computed in WIDTH+1 bits with no overflow;
  - maximum output is 3·2^(WIDTH-2), i.e. 49152 for WIDTH=16.
- Latency: transfer at edge t → mag_val=1 from edge t+2 when there is no stall.
- Throughput: one sample per cycle aggregate; no bubbles with continuous val and mag_rdy=1.
- Pipeline bubble handling: when stage 2 is empty or being drained, stage 1 advances even if stage 1 is empty (the bubble is overwritten). Output order is always grant order.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…; no requester waits more than NREQ-1 transfers.
- Runtime enable changes:
  - clearing req_en[i] blocks new grants to i only; samples already in the pipeline complete normally;
  - all-zero req_en means the block idles and drains.
- Reset mid-operation: in-flight samples are discarded and no mag_val pulse occurs after the reset edge.
- busy = stage-1 valid | stage-2 valid.

Decomposition:
- Shared package, e.g. icfo_pkg:
  - mag output width function WIDTH+1;
  - IDW computation ($clog2(NREQ), minimum 1);
  - constant for the round-robin pointer reset value.
- One natural sub-module, icfo_mag_core: the 2-stage abs/mag pipeline with enable/stall, carrying a sideband ID. Arbitration and the pointer stay in the top level.

Test Plan:
- Single requester, WIDTH=16, req0 = (3000, -4000) with mag_rdy=1 → mag=4000+1500=5500, mag_id=0, mag_val high exactly 2 cycles after the transfer.
- Corner values on req1:
  - (-32768, -32768) → mag=49152;
  - (0,0) → mag=0;
  - (-1, 5) → mag=5;
  - (7, 7) → mag=10 (tie takes the b + a>>1 branch).
- Both requesters continuously valid for 8 cycles, mag_rdy=1 → grant order 0,1,0,1,…; mag_id alternates; 8 results; no bubbles.
- Backpressure: mag_rdy=0 for 3 cycles while mag_val=1 → mag and mag_id stable, req_rdy=0; on release, results resume in order with none lost or duplicated.
- Enable masking: req_en=2'b01 with both requesters valid → only ID 0 results. Clear req_en[0] while a sample is in flight → that result still emerges, then mag_val=0 and busy=0.
- Reset mid-stream: rst=0 with 2 samples in flight → the following cycle mag_val=0, busy=0, req_rdy=0. After rst=1 with both requesters valid, the first grant goes to requester 0.
